axi_rd_arbiter: RTL and testbench

//  Shares one AXI4 read master port between NUM_REQ fetch engines, e.g. the

---
 rtl/axi_rd_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI4 read master port between NUM_REQ fetch engines.
//   AR channel: round-robin arbitration, one address in flight per grant.
//   The winning payload is registered and driven on the master AR channel,
//   with ARID carrying the requester index (zero-extended).
//   R channel: unbuffered. Beats are steered back to the requester named by
//   the low IDX_W bits of RID. Beats naming a non-existent requester are
//   accepted and dropped, and they set a sticky error flag.
//   Each requester may have at most MAX_OUTST bursts outstanding.
//
//   Handshake rule on every channel: a transfer happens on the rising edge
//   where valid and ready are both high. Valid never waits for ready. Once
//   raised, the master AR valid and its payload hold until the transfer.
//
// Ports
//   m_axi_aclk, m_axi_aresetn         clock, async active-low reset
//   s_araddr/arlen/arsize/arburst     packed per-requester AR payload
//   s_arvalid / s_arready             per-requester AR handshake
//   s_rdata/rresp/rlast               broadcast R payload
//   s_rvalid / s_rready               per-requester R handshake
//   m_axi_ar*                         master AR channel (registered)
//   m_axi_r*                          master R channel
//   busy                              AR pending or any burst outstanding
//   err_unmapped                      sticky: beat arrived for an unknown RID
//   dbg_state                         current FSM state (0 = IDLE, 1 = ADDR)
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ID_WIDTH   = 8,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_OUTST          = 4
) (
    input  logic                                  m_axi_aclk,
    input  logic                                  m_axi_aresetn,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]                  s_arlen,
    input  logic [NUM_REQ*3-1:0]                  s_arsize,
    input  logic [NUM_REQ*2-1:0]                  s_arburst,
    input  logic [NUM_REQ-1:0]                    s_arvalid,
    output logic [NUM_REQ-1:0]                    s_arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  s_rlast,
    output logic [NUM_REQ-1:0]                    s_rvalid,
    input  logic [NUM_REQ-1:0]                    s_rready,
    output logic [C_M_AXI_ID_WIDTH-1:0]           m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                            m_axi_arlen,
    output logic [2:0]                            m_axi_arsize,
    output logic [1:0]                            m_axi_arburst,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]           m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready,
    output logic                                  busy,
    output logic                                  err_unmapped,
    output logic                                  dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int IDW   = C_M_AXI_ID_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       cnt_q [NUM_REQ];
    logic [3:0]       cnt_d [NUM_REQ];
    logic [IDW-1:0]   arid_q, arid_d;
    logic [AW-1:0]    araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [2:0]       arsize_q, arsize_d;
    logic [1:0]       arburst_q, arburst_d;
    logic             arvalid_q, arvalid_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   win;
    int                 scan;
    int                 win_i;
    logic               grant;
    logic [IDX_W-1:0]   r_idx;
    logic               r_mapped;
    logic               cmpl;
    logic               any_out;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign eligible[g] = s_arvalid[g] && (cnt_q[g] < 4'(MAX_OUTST));
    end

    // Round-robin pick: first eligible index starting at rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && eligible[IDX_W'(scan)]) begin
                found = 1'b1;
                win   = IDX_W'(scan);
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && found;

    always_comb begin
        s_arready = '0;
        if (grant) s_arready[win] = 1'b1;
    end

    // R routing. With a non-power-of-two NUM_REQ some index codes name no
    // requester; those beats are sunk so the master channel cannot stall.
    always_comb begin
        r_idx        = m_axi_rid[IDX_W-1:0];
        r_mapped     = (int'(r_idx) < NUM_REQ);
        s_rvalid     = '0;
        m_axi_rready = 1'b1;
        if (r_mapped) begin
            s_rvalid[r_idx] = m_axi_rvalid;
            m_axi_rready    = s_rready[r_idx];
        end
    end

    assign cmpl    = r_mapped && m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign s_rdata = m_axi_rdata;
    assign s_rresp = m_axi_rresp;
    assign s_rlast = m_axi_rlast;

    // Outstanding counters: bumped at grant capture, dropped on a routed
    // last beat. Grant and completion together cancel; completion at zero
    // is ignored so a stray rlast cannot wrap the count.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((grant && win == IDX_W'(i)) &&
                !(cmpl && r_idx == IDX_W'(i) && cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (!(grant && win == IDX_W'(i)) &&
                         (cmpl && r_idx == IDX_W'(i) && cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
    end

    always_comb begin
        any_out = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_q[i] != 4'd0) any_out = 1'b1;
        end
    end

    // FSM next state and registered AR payload.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arvalid_d = arvalid_q;
        win_i     = int'(win);
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    arid_d    = IDW'(win);
                    araddr_d  = s_araddr[win_i*AW +: AW];
                    arlen_d   = s_arlen[win_i*8 +: 8];
                    arsize_d  = s_arsize[win_i*3 +: 3];
                    arburst_d = s_arburst[win_i*2 +: 2];
                    arvalid_d = 1'b1;
                    rr_ptr_d  = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_d = err_q | (m_axi_rvalid && !r_mapped);

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= 4'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arvalid = arvalid_q;
    assign busy          = (state_q == ST_ADDR) || any_out;
    assign err_unmapped  = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Directed bench for axi_rd_arbiter with three requesters, so that one
//   index code (3) names no requester. Accepted upstream ARs push their
//   expected master AR payload; driven R beats push their expected routed
//   beat. Negedge monitors pop and compare whenever the DUT presents a
//   transfer. Directed checks cover reset, arbitration order, the
//   outstanding limit, AR stalls, unmapped RIDs and async reset.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int NR  = 3;
    localparam int ARW = 8 + 32 + 8 + 3 + 2;
    localparam int RW  = 8 + 32 + 2 + 1;

    logic            clk;
    logic            rst_n;
    logic [NR*32-1:0] s_araddr;
    logic [NR*8-1:0] s_arlen;
    logic [NR*3-1:0] s_arsize;
    logic [NR*2-1:0] s_arburst;
    logic [NR-1:0]   s_arvalid;
    logic [NR-1:0]   s_arready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [NR-1:0]   s_rvalid;
    logic [NR-1:0]   s_rready;
    logic [7:0]      m_axi_arid;
    logic [31:0]     m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [7:0]      m_axi_rid;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic            busy;
    logic            err_unmapped;
    logic            dbg_state;

    logic [ARW-1:0] ar_exp_q[$];
    logic [RW-1:0]  r_exp_q[$];
    int             grant_log[$];
    int             gcnt[NR];
    int             checks;
    int             failures;

    axi_rd_arbiter #(
        .NUM_REQ(NR), .C_M_AXI_ID_WIDTH(8), .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32), .MAX_OUTST(4)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .err_unmapped(err_unmapped), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [7:0] l, logic [1:0] b);
        s_araddr[i*32 +: 32] = a;
        s_arlen[i*8 +: 8]    = l;
        s_arsize[i*3 +: 3]   = 3'd2;
        s_arburst[i*2 +: 2]  = b;
    endtask

    // Waits (bounded) until requester i has been granted once more.
    task automatic wait_grant(int i);
        int start;
        start = gcnt[i];
        for (int c = 0; c < 30 && gcnt[i] == start; c++) tick();
        check($sformatf("grant_req%0d", i), 64'(gcnt[i] - start), 64'd1);
    endtask

    task automatic send_r(logic [7:0] rid, logic [31:0] data, logic last);
        logic [1:0] idx;
        idx          = rid[1:0];
        m_axi_rid    = rid;
        m_axi_rdata  = data;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = last;
        m_axi_rvalid = 1'b1;
        if (int'(idx) < NR) r_exp_q.push_back({8'(idx), data, 2'b00, last});
        tick();
    endtask

    task automatic r_idle();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        ar_exp_q.delete();
        r_exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (s_arvalid[i] && s_arready[i]) begin
                    ar_exp_q.push_back({8'(i), s_araddr[i*32 +: 32], s_arlen[i*8 +: 8],
                                        s_arsize[i*3 +: 3], s_arburst[i*2 +: 2]});
                    grant_log.push_back(i);
                    gcnt[i]++;
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ar_unexpected: got arid %0h addr %0h, expected no AR",
                             m_axi_arid, m_axi_araddr);
                end else begin
                    check("ar_payload",
                          64'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}),
                          64'(ar_exp_q.pop_front()));
                end
            end
            check("s_rvalid_onehot", 64'($countones(s_rvalid) <= 1), 64'd1);
            for (int i = 0; i < NR; i++) begin
                if (s_rvalid[i] && s_rready[i]) begin
                    if (r_exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL r_unexpected: got beat for req %0d data %0h, expected none",
                                 i, s_rdata);
                    end else begin
                        check("r_beat", 64'({8'(i), s_rdata, s_rresp, s_rlast}),
                              64'(r_exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int g1;
        logic [7:0] exp_order [4];
        checks = 0;
        failures = 0;
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        rst_n = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arvalid = '0; s_rready = '1;
        m_axi_arready = 1'b1;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        // reset values
        #7;
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_ar_payload",
              64'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_unmapped), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("idle_arready", 64'(s_arready), 64'd0);

        // 1: single req0 burst, len 3
        set_req(0, 32'h1000, 8'd3, 2'b01);
        s_arvalid[0] = 1'b1;
        #1;
        check("t1_arready", 64'(s_arready), 64'b001);
        wait_grant(0);
        s_arvalid[0] = 1'b0;
        check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("t1_arid", 64'(m_axi_arid), 64'd0);
        for (int b = 0; b < 4; b++) send_r(8'h00, 32'hC0DE_0000 + 32'(b), b == 3);
        r_idle();
        tick();
        check("t1_busy", 64'(busy), 64'd0);

        // 2: two requesters held valid alternate from a fresh pointer
        apply_reset();
        base = grant_log.size();
        set_req(0, 32'h0100, 8'd0, 2'b01);
        set_req(1, 32'h0200, 8'd0, 2'b10);
        s_arvalid = 3'b011;
        for (int c = 0; c < 40 && grant_log.size() < base + 4; c++) tick();
        s_arvalid = '0;
        exp_order[0] = 8'd0; exp_order[1] = 8'd1; exp_order[2] = 8'd0; exp_order[3] = 8'd1;
        check("t2_grants", 64'(grant_log.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < grant_log.size())
                check($sformatf("t2_order%0d", k), 64'(grant_log[base + k]), 64'(exp_order[k]));
        end
        tick();
        send_r(8'h00, 32'h2000_0001, 1'b1);
        send_r(8'h01, 32'h2000_0002, 1'b1);
        send_r(8'h00, 32'h2000_0003, 1'b1);
        send_r(8'h01, 32'h2000_0004, 1'b1);
        r_idle();
        tick();
        check("t2_busy", 64'(busy), 64'd0);

        // 3: outstanding limit on req1
        for (int n = 0; n < 4; n++) begin
            set_req(1, 32'h0400 + 32'(n * 64), 8'd1, 2'b01);
            s_arvalid[1] = 1'b1;
            wait_grant(1);
            s_arvalid[1] = 1'b0;
        end
        set_req(0, 32'h0800, 8'd0, 2'b01);
        set_req(1, 32'h0900, 8'd0, 2'b01);
        s_arvalid = 3'b011;
        g1 = gcnt[1];
        wait_grant(0);
        s_arvalid[0] = 1'b0;
        repeat (4) tick();
        check("t3_req1_held", 64'(gcnt[1] - g1), 64'd0);
        check("t3_arready_zero", 64'(s_arready), 64'd0);
        send_r(8'h01, 32'h3000_0001, 1'b1);
        r_idle();
        wait_grant(1);
        s_arvalid[1] = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) send_r(8'h01, 32'h3100_0000 + 32'(n), 1'b1);
        send_r(8'h00, 32'h3200_0000, 1'b1);
        r_idle();
        tick();
        check("t3_busy", 64'(busy), 64'd0);

        // 4: master stalls AR for 10 cycles
        m_axi_arready = 1'b0;
        set_req(2, 32'h2000, 8'd7, 2'b01);
        s_arvalid[2] = 1'b1;
        wait_grant(2);
        s_arvalid[2] = 1'b0;
        set_req(0, 32'h3000, 8'd0, 2'b10);
        s_arvalid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t4_stall%0d", c),
                  64'({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, s_arready}),
                  64'({1'b1, 8'd2, 32'h2000, 8'd7, 3'b000}));
            check($sformatf("t4_busy%0d", c), 64'(busy), 64'd1);
            tick();
        end
        m_axi_arready = 1'b1;
        wait_grant(0);
        s_arvalid[0] = 1'b0;
        tick();
        for (int b = 0; b < 8; b++) send_r(8'h02, 32'hA000 + 32'(b), b == 7);
        send_r(8'h00, 32'hB000, 1'b1);
        r_idle();
        tick();
        check("t4_busy_done", 64'(busy), 64'd0);

        // 5: unmapped RID index 3, then upper RID bits ignored (0x05 -> req1)
        s_rready = 3'b000;
        m_axi_rid = 8'h07; m_axi_rdata = 32'hDEAD; m_axi_rlast = 1'b1; m_axi_rvalid = 1'b1;
        #1;
        check("t5_rready_sink", 64'(m_axi_rready), 64'd1);
        check("t5_no_rvalid", 64'(s_rvalid), 64'd0);
        tick();
        check("t5_err_set", 64'(err_unmapped), 64'd1);
        m_axi_rid = 8'h05;
        #1;
        check("t5_route_upper", 64'(s_rvalid), 64'b010);
        check("t5_backpressure", 64'(m_axi_rready), 64'd0);
        s_rready = 3'b111;
        send_r(8'h05, 32'h5555, 1'b1);
        r_idle();
        repeat (3) tick();
        check("t5_err_sticky", 64'(err_unmapped), 64'd1);
        check("t5_no_wrap", 64'(busy), 64'd0);

        // 6: async reset while in ADDR
        m_axi_arready = 1'b0;
        set_req(1, 32'h6000, 8'd3, 2'b01);
        s_arvalid[1] = 1'b1;
        wait_grant(1);
        s_arvalid[1] = 1'b0;
        tick();
        check("t6_arvalid_pre", 64'(m_axi_arvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arvalid_async", 64'(m_axi_arvalid), 64'd0);
        check("t6_busy_in_rst", 64'(busy), 64'd0);
        ar_exp_q.delete();
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        check("t6_busy_post", 64'(busy), 64'd0);
        check("t6_err_cleared", 64'(err_unmapped), 64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        m_axi_arready = 1'b1;
        set_req(2, 32'h7000, 8'd0, 2'b01);
        s_arvalid[2] = 1'b1;
        wait_grant(2);
        s_arvalid[2] = 1'b0;
        tick();
        send_r(8'h02, 32'h7777, 1'b1);
        r_idle();
        tick();
        check("t6_final_busy", 64'(busy), 64'd0);

        // ---------------- final report ----------------
        repeat (2) tick();
        check("ar_queue_drained", 64'(ar_exp_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
